// File: rtl/vscale_lockstep_checker.sv
// N-way lockstep trace comparator: per-copy FIFOs absorb skew, aligned
// heads are compared against copy 0 with sticky mismatch/overflow/stall.
module vscale_lockstep_checker #(
  parameter int NUM_COPIES       = 2,
  parameter int TRACE_W          = 64,
  parameter int DEPTH            = 8,
  parameter int SETTLE_CYCLES    = 1,
  parameter int TIMEOUT          = 64,
  parameter int STOP_ON_MISMATCH = 1,
  parameter int CNT_W            = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_COPIES-1:0]         i_trace_valid,
  input  logic [NUM_COPIES*TRACE_W-1:0] i_trace_data,
  output logic                          o_armed,
  output logic                          o_cmp_valid,
  output logic                          o_mismatch,
  output logic [NUM_COPIES-1:0]         o_mismatch_mask,
  output logic [TRACE_W-1:0]            o_mismatch_ref,
  output logic [NUM_COPIES-1:0]         o_overflow,
  output logic                          o_divergence_stall,
  output logic [CNT_W-1:0]              o_compare_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_ARMING,
    S_RUN,
    S_HALT
  } state_t;

  state_t             r_state;
  logic [SW-1:0]      r_settle;
  logic [TW-1:0]      r_timer;
  logic [TRACE_W-1:0] r_mem [NUM_COPIES][DEPTH];
  logic [PW-1:0]      r_wp  [NUM_COPIES];
  logic [PW-1:0]      r_rp  [NUM_COPIES];

  logic [NUM_COPIES-1:0] w_empty;
  logic [NUM_COPIES-1:0] w_full;
  logic [NUM_COPIES-1:0] w_push;
  logic [NUM_COPIES-1:0] w_wr;
  logic [NUM_COPIES-1:0] w_diff;
  logic [TRACE_W-1:0]    w_head [NUM_COPIES];
  logic                  w_run;
  logic                  w_pop;
  logic                  w_stall_cond;
  logic [TW-1:0]         w_timer_nxt;

  always_comb begin
    w_run = (r_state == S_RUN);
    for (int i = 0; i < NUM_COPIES; i++) begin
      w_empty[i] = (r_wp[i] == r_rp[i]);
      w_full[i]  = (r_wp[i][AW] != r_rp[i][AW]) &&
                   (r_wp[i][AW-1:0] == r_rp[i][AW-1:0]);
      w_head[i]  = r_mem[i][r_rp[i][AW-1:0]];
    end
    w_pop = w_run && !(|w_empty);
    // a full FIFO may still accept when its head leaves on the same edge
    for (int i = 0; i < NUM_COPIES; i++) begin
      w_push[i] = w_run && i_trace_valid[i];
      w_wr[i]   = w_push[i] && (!w_full[i] || w_pop);
    end
    w_diff = '0;
    for (int j = 1; j < NUM_COPIES; j++) begin
      w_diff[j] = (w_head[j] != w_head[0]);
    end
    w_stall_cond = w_run && (|(~w_empty)) && (|w_empty);
    if (!w_stall_cond) begin
      w_timer_nxt = '0;
    end else if (r_timer == TMAX) begin
      w_timer_nxt = TMAX;
    end else begin
      w_timer_nxt = r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_COPIES; i++) begin
      if (w_wr[i]) begin
        r_mem[i][r_wp[i][AW-1:0]] <= i_trace_data[i*TRACE_W +: TRACE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_ARMING;
      r_settle           <= SETTLE_INIT;
      r_timer            <= '0;
      o_armed            <= 1'b0;
      o_cmp_valid        <= 1'b0;
      o_mismatch         <= 1'b0;
      o_mismatch_mask    <= '0;
      o_mismatch_ref     <= '0;
      o_overflow         <= '0;
      o_divergence_stall <= 1'b0;
      o_compare_count    <= '0;
      for (int i = 0; i < NUM_COPIES; i++) begin
        r_wp[i] <= '0;
        r_rp[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_ARMING: begin
          o_cmp_valid <= 1'b0;
          if (r_settle == '0) begin
            r_state <= S_RUN;
            o_armed <= 1'b1;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        S_RUN: begin
          o_cmp_valid <= w_pop;
          for (int i = 0; i < NUM_COPIES; i++) begin
            if (w_wr[i]) r_wp[i] <= r_wp[i] + 1'b1;
            if (w_pop) r_rp[i] <= r_rp[i] + 1'b1;
            if (w_push[i] && !w_wr[i]) o_overflow[i] <= 1'b1;
          end
          if (w_pop) begin
            if (o_compare_count != '1) begin
              o_compare_count <= o_compare_count + 1'b1;
            end
            if ((|w_diff) && !o_mismatch) begin
              o_mismatch      <= 1'b1;
              o_mismatch_mask <= w_diff;
              o_mismatch_ref  <= w_head[0];
              if (STOP_ON_MISMATCH != 0) begin
                r_state <= S_HALT;
                o_armed <= 1'b0;
              end
            end
          end
          r_timer <= w_timer_nxt;
          if (w_timer_nxt == TMAX) o_divergence_stall <= 1'b1;
        end
        S_HALT: begin
          o_cmp_valid <= 1'b0;
        end
        default: begin
          r_state <= S_HALT;
          o_armed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_lockstep_checker.sv
// Directed bench: queue-based model of two checker instances (2-copy halting,
// 3-copy free-running) compared every cycle, plus literal expectations.
module tb_vscale_lockstep_checker;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   tv_a = '0;
  logic [127:0] td_a = '0;
  logic [2:0]   tv_b = '0;
  logic [191:0] td_b = '0;

  logic        armed_a, cmp_a, mis_a, stall_a;
  logic [1:0]  mask_a, ovf_a;
  logic [63:0] ref_a;
  logic [15:0] cnt_a;
  logic        armed_b, cmp_b, mis_b, stall_b;
  logic [2:0]  mask_b, ovf_b;
  logic [63:0] ref_b;
  logic [15:0] cnt_b;

  always #5 clk = ~clk;

  vscale_lockstep_checker u_a (
    .clk(clk), .reset(reset),
    .i_trace_valid(tv_a), .i_trace_data(td_a),
    .o_armed(armed_a), .o_cmp_valid(cmp_a),
    .o_mismatch(mis_a), .o_mismatch_mask(mask_a),
    .o_mismatch_ref(ref_a), .o_overflow(ovf_a),
    .o_divergence_stall(stall_a), .o_compare_count(cnt_a)
  );

  vscale_lockstep_checker #(
    .NUM_COPIES(3), .STOP_ON_MISMATCH(0)
  ) u_b (
    .clk(clk), .reset(reset),
    .i_trace_valid(tv_b), .i_trace_data(td_b),
    .o_armed(armed_b), .o_cmp_valid(cmp_b),
    .o_mismatch(mis_b), .o_mismatch_mask(mask_b),
    .o_mismatch_ref(ref_b), .o_overflow(ovf_b),
    .o_divergence_stall(stall_b), .o_compare_count(cnt_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_en = 0;
  int          m_st [2];
  int          m_settle [2];
  int          m_timer [2];
  logic [63:0] mq [2][3][$];
  logic        e_cmp [2];
  logic        e_mis [2];
  logic        e_stall [2];
  logic [2:0]  e_mask [2];
  logic [2:0]  e_ovf [2];
  logic [63:0] e_ref [2];
  int          e_cnt [2];

  task automatic model_step(input int k);
    int n, ne, em;
    logic [2:0] diff;
    logic [63:0] d;
    logic v;
    n = (k == 0) ? 2 : 3;
    if (reset) begin
      m_st[k] = 0; m_settle[k] = 1; m_timer[k] = 0;
      e_cmp[k] = 0; e_mis[k] = 0; e_stall[k] = 0;
      e_mask[k] = 0; e_ovf[k] = 0; e_ref[k] = 0; e_cnt[k] = 0;
      for (int c = 0; c < 3; c++) mq[k][c].delete();
      return;
    end
    if (m_st[k] == 0) begin
      e_cmp[k] = 0;
      if (m_settle[k] == 0) m_st[k] = 1;
      else m_settle[k]--;
    end else if (m_st[k] == 2) begin
      e_cmp[k] = 0;
    end else begin
      ne = 0; em = 0;
      for (int c = 0; c < n; c++) begin
        if (mq[k][c].size() == 0) em++;
        else ne++;
      end
      e_cmp[k] = (em == 0);
      if (em == 0) begin
        if (e_cnt[k] < 65535) e_cnt[k]++;
        diff = 0;
        for (int c = 1; c < n; c++)
          if (mq[k][c][0] != mq[k][0][0]) diff[c] = 1'b1;
        if (diff != 0 && !e_mis[k]) begin
          e_mis[k] = 1; e_mask[k] = diff; e_ref[k] = mq[k][0][0];
          if (k == 0) m_st[k] = 2;
        end
        for (int c = 0; c < n; c++) void'(mq[k][c].pop_front());
      end
      if (ne > 0 && em > 0) begin
        if (m_timer[k] < 64) m_timer[k]++;
      end else begin
        m_timer[k] = 0;
      end
      if (m_timer[k] == 64) e_stall[k] = 1;
      for (int c = 0; c < n; c++) begin
        v = (k == 0) ? tv_a[c] : tv_b[c];
        d = (k == 0) ? td_a[c*64 +: 64] : td_b[c*64 +: 64];
        if (v) begin
          if (mq[k][c].size() >= 8) e_ovf[k][c] = 1'b1;
          else mq[k][c].push_back(d);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (reset) m_en = 1;
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("a.armed", 64'(armed_a), 64'(m_st[0] == 1));
      chk("a.cmp_valid", 64'(cmp_a), 64'(e_cmp[0]));
      chk("a.mismatch", 64'(mis_a), 64'(e_mis[0]));
      chk("a.mask", 64'(mask_a), 64'(e_mask[0][1:0]));
      chk("a.ref", ref_a, e_ref[0]);
      chk("a.overflow", 64'(ovf_a), 64'(e_ovf[0][1:0]));
      chk("a.stall", 64'(stall_a), 64'(e_stall[0]));
      chk("a.count", 64'(cnt_a), 64'(e_cnt[0]));
      chk("b.armed", 64'(armed_b), 64'(m_st[1] == 1));
      chk("b.cmp_valid", 64'(cmp_b), 64'(e_cmp[1]));
      chk("b.mismatch", 64'(mis_b), 64'(e_mis[1]));
      chk("b.mask", 64'(mask_b), 64'(e_mask[1]));
      chk("b.ref", ref_b, e_ref[1]);
      chk("b.overflow", 64'(ovf_b), 64'(e_ovf[1]));
      chk("b.stall", 64'(stall_b), 64'(e_stall[1]));
      chk("b.count", 64'(cnt_b), 64'(e_cnt[1]));
    end
  end

  int pulses_a = 0;
  int pulses_b = 0;
  always @(negedge clk) begin
    if (reset) begin
      pulses_a = 0; pulses_b = 0;
    end else begin
      pulses_a += int'(cmp_a);
      pulses_b += int'(cmp_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tv_a = '0; tv_b = '0; td_a = '0; td_b = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) cyc();
    @(negedge clk);
  endtask

  function automatic logic [63:0] dat(input int i);
    return 64'h0000_1000_0000_0000 + 64'(i);
  endfunction

  initial begin
    // T1: identical streams, junk pushed during settle is ignored
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tv_a = 2'b11;
      td_a[63:0]   = (c < 2) ? 64'hAAAA : dat(c - 2);
      td_a[127:64] = (c < 2) ? 64'h5555 : dat(c - 2);
      cyc();
    end
    drain(4);
    chk("t1.pulses", 64'(pulses_a), 64'd10);
    chk("t1.count", 64'(cnt_a), 64'd10);
    chk("t1.mismatch", 64'(mis_a), 64'd0);

    // T2: copy 1 lags copy 0 by five cycles
    do_reset();
    for (int c = 0; c < 17; c++) begin
      tv_a[0] = (c >= 2 && c < 12);
      tv_a[1] = (c >= 7 && c < 17);
      td_a[63:0]   = dat(c - 2);
      td_a[127:64] = dat(c - 7);
      cyc();
    end
    drain(3);
    chk("t2.overflow", 64'(ovf_a), 64'd0);
    chk("t2.count", 64'(cnt_a), 64'd10);
    chk("t2.stall", 64'(stall_a), 64'd0);
    chk("t2.mismatch", 64'(mis_a), 64'd0);

    // T3: fourth entry differs, halting instance
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tv_a = (c >= 2) ? 2'b11 : 2'b00;
      td_a[63:0]   = (c == 5) ? 64'hBEEF : 64'h100 + 64'(c);
      td_a[127:64] = (c == 5) ? 64'hDEAD : 64'h100 + 64'(c);
      cyc();
    end
    drain(4);
    chk("t3.mismatch", 64'(mis_a), 64'd1);
    chk("t3.mask", 64'(mask_a), 64'd2);
    chk("t3.ref", ref_a, 64'hBEEF);
    chk("t3.count", 64'(cnt_a), 64'd4);
    chk("t3.pulses", 64'(pulses_a), 64'd4);
    chk("t3.armed", 64'(armed_a), 64'd0);

    // T4: three copies, copy 2 differs at entries 2 and 6, keep comparing
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tv_b = (c >= 2) ? 3'b111 : 3'b000;
      td_b[63:0]    = dat(c - 2);
      td_b[127:64]  = dat(c - 2);
      td_b[191:128] = (c == 3 || c == 7) ? dat(c - 2) ^ 64'hFF : dat(c - 2);
      cyc();
    end
    drain(4);
    chk("t4.mismatch", 64'(mis_b), 64'd1);
    chk("t4.mask", 64'(mask_b), 64'd4);
    chk("t4.ref", ref_b, dat(1));
    chk("t4.count", 64'(cnt_b), 64'd10);
    chk("t4.pulses", 64'(pulses_b), 64'd10);

    // T5: copy 1 silent; ninth push overflows, stall after timeout
    do_reset();
    for (int c = 0; c < 11; c++) begin
      tv_a = (c >= 2) ? 2'b01 : 2'b00;
      td_a[63:0] = dat(c);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t5.overflow", 64'(ovf_a), 64'd1);
    chk("t5.stall_early", 64'(stall_a), 64'd0);
    drain(50);
    chk("t5.stall_pre", 64'(stall_a), 64'd0);
    drain(10);
    chk("t5.stall", 64'(stall_a), 64'd1);
    chk("t5.count", 64'(cnt_a), 64'd0);

    // T6: reset with three entries buffered on copy 0 only
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tv_a = (c >= 2) ? 2'b01 : 2'b00;
      td_a[63:0] = 64'h77 + 64'(c);
      cyc();
    end
    idle();
    @(negedge clk);
    chk("t6.armed_pre", 64'(armed_a), 64'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("t6.armed_rst", 64'(armed_a), 64'd0);
    chk("t6.outs_rst", {ovf_a, stall_a, mis_a, cmp_a, cnt_a}, 64'd0);
    cyc();
    @(negedge clk);
    chk("t6.armed_settle", 64'(armed_a), 64'd0);
    cyc();
    @(negedge clk);
    chk("t6.armed_run", 64'(armed_a), 64'd1);
    for (int c = 0; c < 2; c++) begin
      tv_a = 2'b11;
      td_a[63:0]   = dat(40 + c);
      td_a[127:64] = dat(40 + c);
      cyc();
    end
    drain(3);
    chk("t6.count", 64'(cnt_a), 64'd2);
    chk("t6.mismatch", 64'(mis_a), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vscale_lockstep_checker.md
Name: vscale_lockstep_checker

Overview:
- N-way lockstep trace comparator for duplicated vscale_sim_top instances in two-/multi-trace formal and simulation harnesses.
- Buffers per-copy retirement traces in per-copy FIFOs, absorbing inter-copy skew.
- Compares aligned entries against copy 0, flags divergence, stalls and overflow.
- Post-reset settle window generalises the single-cycle "first" mask to a parameterised arming counter.

Parameters:
- NUM_COPIES, 2, number of duplicated cores/traces (2..8).
- TRACE_W, 64, bits per trace entry (e.g. {pc, wdata}).
- DEPTH, 8, per-copy FIFO entries; power of two, ≥2.
- SETTLE_CYCLES, 1, cycles after reset release during which pushes are ignored; 0 allowed.
- TIMEOUT, 64, stall cycles before divergence_stall fires.
- STOP_ON_MISMATCH, 1, 1: freeze on first mismatch; 0: keep comparing.
- CNT_W, 16, width of compare_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- trace_valid  in  NUM_COPIES  per-copy retire strobe.
- trace_data  in  NUM_COPIES*TRACE_W  packed entries; copy i at [i*TRACE_W +: TRACE_W].
- armed  out  1  settle window elapsed and not halted.
- cmp_valid  out  1  one-cycle pulse: a comparison completed.
- mismatch  out  1  sticky: any comparison disagreed.
- mismatch_mask  out  NUM_COPIES  copies differing from copy 0 at first mismatch; bit 0 always 0.
- mismatch_ref  out  TRACE_W  copy-0 entry at first mismatch.
- overflow  out  NUM_COPIES  sticky per-copy FIFO overflow.
- divergence_stall  out  1  sticky timeout flag.
- compare_count  out  CNT_W  completed comparisons, saturating.

Behaviour:
- Reset values: all outputs 0; FIFOs empty; state ARMING; settle counter = SETTLE_CYCLES.
- ARMING: pushes ignored. Counter decrements each cycle. At 0, go to RUN; with SETTLE_CYCLES=0, RUN is reached the cycle after reset deasserts. armed=1 in RUN only.
- Push (RUN only): trace_valid[i] writes trace_data slice i into FIFO i the same edge.
- Pop/compare (RUN): when every FIFO is non-empty, pop all heads that edge.
  - Result registered: cmp_valid=1 next cycle; compare_count increments the same cycle, saturating at 2^CNT_W-1.
  - Head of copy j ≠ head of copy 0 → mismatch_mask[j] set.
- First mismatch: mismatch, mismatch_mask and mismatch_ref captured once; later mismatches do not update the capture.
  - STOP_ON_MISMATCH=1: go to HALT in the same cycle mismatch rises.
  - STOP_ON_MISMATCH=0: stay in RUN.
- HALT: no pushes or pops; cmp_valid=0; all flags frozen. Exit only via reset.
- Full FIFO:
  - Push when full and not popped that edge → entry dropped, overflow[i] set.
  - Push when full and popped that edge is legal; occupancy stays DEPTH.
- Stall timer:
  - Increments each RUN cycle in which ≥1 FIFO is non-empty and ≥1 is empty; clears otherwise.
  - Reaching TIMEOUT sets divergence_stall (sticky); timer holds.
  - Comparisons continue after divergence_stall.
- Simultaneous push and pop on the same FIFO: both take effect. An empty FIFO pushed this edge is not compared until the next edge (no bypass).
- Pointers are log2(DEPTH)+1 bits; full/empty from MSB compare; wrap-around must be seamless.
- Reset mid-operation: all state cleared in one cycle; in-flight entries discarded; the settle window restarts.

Test Plan:
- NUM_COPIES=2, SETTLE_CYCLES=1; identical 10-entry streams, both valid every cycle from cycle 2 → cmp_valid pulses 10 times, compare_count=10, mismatch=0; an entry pushed during the settle cycle is not compared.
- Copy 1 delayed 5 cycles vs copy 0, same data, DEPTH=8 → no overflow, compare_count=10, divergence_stall=0.
- 4th entry of copy 1 = 0xDEAD vs copy 0 0xBEEF, STOP_ON_MISMATCH=1 → mismatch=1, mismatch_mask=2'b10, mismatch_ref=0xBEEF, compare_count=4, no further cmp_valid.
- NUM_COPIES=3, STOP_ON_MISMATCH=0, copy 2 differs at entries 2 and 6 → mismatch_mask=3'b100 from entry 2 capture, compare_count=10.
- Copy 0 pushes 9 entries, copy 1 silent → overflow=2'b01 after the 9th push; divergence_stall=1 after 64 cycles.
- Reset asserted mid-stream with 3 entries buffered → next cycle all outputs 0, armed=0; armed=1 after SETTLE_CYCLES; stale entries never compared.
